// File: rtl/addsub_chunked.sv
// Multi-cycle add/subtract unit resolving CHUNK bits per clock.
// A start/busy/done handshake surrounds it, and it reports carry, signed overflow and zero flags.
module addsub_chunked #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK:0]   w_csum;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_full;

  assign w_last = (r_idx == IDX_W'(NCHUNK - 1));

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operands shift down one chunk per step, so the low chunk is always the active one
  assign w_ca      = r_a[CHUNK-1:0];
  assign w_cb      = r_b[CHUNK-1:0];
  assign w_csum    = {1'b0, w_ca} + {1'b0, w_cb} + (CHUNK+1)'(r_carry);
  assign w_msb_cin = w_ca[CHUNK-1] ^ w_cb[CHUNK-1] ^ w_csum[CHUNK-1];

  // New chunk enters at the top of the partial sum; after NCHUNK steps it is aligned
  assign w_full = WIDTH'({w_csum[CHUNK-1:0], r_sum} >> CHUNK);

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_RUN);
      done    <= (w_state_nxt == S_DONE);
      if (w_load) begin
        r_a     <= a;
        r_b     <= op_sub ? ~b : b;
        r_carry <= op_sub;
        r_idx   <= '0;
      end else if (w_step) begin
        r_a     <= r_a >> CHUNK;
        r_b     <= r_b >> CHUNK;
        r_carry <= w_csum[CHUNK];
        r_idx   <= r_idx + IDX_W'(1);
        r_sum   <= w_full;
        if (w_last) begin
          result    <= w_full;
          carry_out <= w_csum[CHUNK];
          overflow  <= w_msb_cin ^ w_csum[CHUNK];
          zero      <= (w_full == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_chunked.sv
// Directed bench for addsub_chunked: an 8-bit-chunk instance and a full-width-chunk instance
// share the same stimulus.
module tb_addsub_chunked;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic [31:0] a;
  logic [31:0] b;

  logic        busy0, done0, co0, ov0, z0;
  logic [31:0] res0;
  logic        busy1, done1, co1, ov1, z1;
  logic [31:0] res1;

  int n_cmp  = 0;
  int n_fail = 0;

  addsub_chunked #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy0), .done(done0), .result(res0), .carry_out(co0),
    .overflow(ov0), .zero(z0)
  );

  addsub_chunked #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1), .carry_out(co1),
    .overflow(ov1), .zero(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) tick();
  endtask

  // Issue one start pulse to dut0 and follow it until done or a cycle budget expires
  task automatic run_op(input logic sub, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] r, output logic [3:0] flags,
                        output int lat, output int bcnt, output logic changed);
    logic [31:0] r_before;
    r_before = res0;
    changed  = 1'b0;
    op_sub = sub; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; op_sub = ~sub;
    lat = 0; bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy0) bcnt++;
      if (done0) break;
      if (res0 !== r_before) changed = 1'b1;
      tick();
      lat++;
    end
    if (!done0) lat = 99;
    r     = res0;
    flags = {co0, ov0, z0, done0};
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy0, done0, co0, ov0, z0} !== 5'b0 || res0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dut0: busy=%b done=%b res=%h co=%b ov=%b z=%b, required all 0",
               busy0, done0, res0, co0, ov0, z0);
    end
    n_cmp++;
    if ({busy1, done1, co1, ov1, z1} !== 5'b0 || res1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_dut1: busy=%b done=%b res=%h, required all 0", busy1, done1, res1);
    end
  endtask

  // Each vector: op, a, b, expected result, expected {co,ov,z}
  task automatic test_arith();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, bcnt;
    logic        ch;
    logic        v_op [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] v_a  [6]  = '{32'h7FFF_FFFF, 32'h5, 32'h1234_5678, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h00FF_FFFF};
    logic [31:0] v_b  [6]  = '{32'h1, 32'h7, 32'h1234_5678, 32'h1, 32'h1, 32'h0000_0001};
    logic [31:0] v_r  [6]  = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h0, 32'h0,
                               32'h7FFF_FFFF, 32'h0100_0000};
    logic [2:0]  v_f  [6]  = '{3'b010, 3'b000, 3'b101, 3'b101, 3'b110, 3'b000};
    for (int i = 0; i < 6; i++) begin
      idle(2);
      run_op(v_op[i], v_a[i], v_b[i], r, f, lat, bcnt, ch);
      n_cmp++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL latency[%0d]: got %0d cycles, required 4", i, lat);
      end
      n_cmp++;
      if (r !== v_r[i] || f[3:1] !== v_f[i]) begin
        n_fail++;
        $display("FAIL arith[%0d]: result=%h {co,ov,z}=%b, required result=%h {co,ov,z}=%b",
                 i, r, f[3:1], v_r[i], v_f[i]);
      end
      n_cmp++;
      if (bcnt !== 4) begin
        n_fail++;
        $display("FAIL busy_cycles[%0d]: got %0d, required 4", i, bcnt);
      end
      n_cmp++;
      if (ch !== 1'b0) begin
        n_fail++;
        $display("FAIL result_stable[%0d]: result changed during RUN, required stable", i);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int          dcnt;
    logic [31:0] rcap;
    idle(2);
    op_sub = 1'b0; a = 32'd1; b = 32'd2; start = 1'b1;
    tick();
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    dcnt = 0; rcap = 32'hX;
    if (done0) begin dcnt++; rcap = res0; end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done0) begin dcnt++; rcap = res0; end
    end
    n_cmp++;
    if (dcnt !== 1 || rcap !== 32'd3) begin
      n_fail++;
      $display("FAIL ignore_busy: done pulses=%0d result=%h, required 1 pulse result=00000003",
               dcnt, rcap);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    logic [3:0]  f;
    int          lat, bcnt;
    logic        ch;
    idle(2);
    op_sub = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_midrun: busy=%b done=%b result=%h, required 0 0 00000000",
               busy0, done0, res0);
    end
    idle(1);
    n_cmp++;
    if (done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b, required 0", done0);
    end
    run_op(1'b0, 32'h1111_1111, 32'h2222_2222, r, f, lat, bcnt, ch);
    n_cmp++;
    if (lat !== 4 || r !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL after_reset_op: latency=%0d result=%h, required 4 33333333", lat, r);
    end
  endtask

  task automatic test_back_to_back();
    idle(2);
    op_sub = 1'b0; a = 32'd10; b = 32'd20; start = 1'b1;
    tick();
    repeat (4) tick();
    n_cmp++;
    if (done0 !== 1'b1 || res0 !== 32'd30) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b result=%h, required 1 0000001e", done0, res0);
    end
    a = 32'd100; b = 32'd1; op_sub = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_gap: busy=%b done=%b, required 1 0", busy0, done0);
    end
    repeat (4) tick();
    n_cmp++;
    if (done0 !== 1'b1 || res0 !== 32'd99 || co0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b result=%h co=%b, required 1 00000063 1",
               done0, res0, co0);
    end
  endtask

  task automatic test_full_chunk();
    idle(8);
    op_sub = 1'b0; a = 32'd1; b = 32'd2; start = 1'b1;
    tick();
    n_cmp++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL c32_busy: busy=%b done=%b, required 1 0", busy1, done1);
    end
    a = 32'd50; b = 32'd8; op_sub = 1'b1;
    tick();
    n_cmp++;
    if (done1 !== 1'b1 || res1 !== 32'd3) begin
      n_fail++;
      $display("FAIL c32_first: done=%b result=%h, required 1 00000003", done1, res1);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL c32_no_gap: busy=%b done=%b, required 1 0", busy1, done1);
    end
    tick();
    n_cmp++;
    if (done1 !== 1'b1 || res1 !== 32'd42 || {co1, ov1, z1} !== 3'b100) begin
      n_fail++;
      $display("FAIL c32_second: done=%b result=%h {co,ov,z}=%b, required 1 0000002a 100",
               done1, res1, {co1, ov1, z1});
    end
    idle(8);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    reset = 1'b0;
    test_reset();
    test_arith();
    test_ignore_busy();
    test_reset_midrun();
    test_back_to_back();
    test_full_chunk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
